disto_loader: RTL and testbench

Request-side sequencer for the 16x16 weighted-transform distortion unit. Accepts a source block and a candidate reconstruction one row per beat over a valid/ready stream and assembles them into the flat buses the distortion unit consumes. It then pulses its start, waits for its done, and returns the 32-bit distortion with a tag over a valid/ready result stream. It sits between the mode-decision pixel fetch and the distortion unit, one instance per unit.

---
 rtl/disto_loader.sv | 128 ++++++++++++
 tb/tb_disto_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/disto_loader.sv
// Row-beat loader and start/done sequencer for the 16x16 weighted-transform distortion unit.
// Optional WAIT watchdog enabled by defining DISTO_LOADER_TIMEOUT_EN.
module disto_loader #(
  parameter int BIT_WIDTH   = 8,
  parameter int BLOCK_SIZE  = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               row_valid,
  output logic                               row_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]    row_a,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]    row_b,
  input  logic [3:0]                         row_tag,
  input  logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0] w_in,
  output logic                               dst_start,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] dst_ina,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] dst_inb,
  output logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0] dst_w,
  input  logic [31:0]                        dst_sum,
  input  logic                               dst_done,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [31:0]                        res_sum,
  output logic [3:0]                         res_tag,
  output logic                               res_err
);

  localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
  localparam int BLK_W = ROW_W * BLOCK_SIZE;
  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_OUT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_row;
  logic [BLK_W-1:0]   r_buf_a;
  logic [BLK_W-1:0]   r_buf_b;
  logic [3:0]         r_tag;
  logic [31:0]        r_sum;
  logic               w_beat;
  logic               w_last;
  logic               w_expire;

  assign w_beat = (r_state == S_LOAD) && row_valid;
  assign w_last = (r_row == CNT_W'(BLOCK_SIZE - 1));

`ifdef DISTO_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_wait_cnt;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_FIRE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Expiry is flagged during the TIMEOUT_CYC-th WAIT cycle; a done in that cycle still wins.
  assign w_expire = (r_state == S_WAIT) && (r_wait_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (dst_done)      r_err <= 1'b0;
      else if (w_expire) r_err <= 1'b1;
    end
  end

  assign res_err = r_err;
`else
  assign w_expire = 1'b0;
  assign res_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_beat && w_last)       w_next = S_FIRE;
      S_FIRE:                              w_next = S_WAIT;
      S_WAIT:  if (dst_done || w_expire)   w_next = S_OUT;
      S_OUT:   if (res_ready)              w_next = S_LOAD;
      default:                             w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= '0;
      r_buf_a <= '0;
      r_buf_b <= '0;
      r_tag   <= '0;
      r_sum   <= '0;
    end else begin
      if (w_beat) begin
        r_buf_a[int'(r_row)*ROW_W +: ROW_W] <= row_a;
        r_buf_b[int'(r_row)*ROW_W +: ROW_W] <= row_b;
        r_row <= w_last ? '0 : r_row + 1'b1;
        if (r_row == '0) r_tag <= row_tag;
      end
      if (r_state == S_WAIT) begin
        if (dst_done)      r_sum <= dst_sum;
        else if (w_expire) r_sum <= 32'hFFFF_FFFF;
      end
    end
  end

  assign row_ready = (r_state == S_LOAD);
  assign dst_start = (r_state == S_FIRE);
  assign res_valid = (r_state == S_OUT);
  assign res_sum   = r_sum;
  assign res_tag   = r_tag;
  assign dst_ina   = r_buf_a;
  assign dst_inb   = r_buf_b;
  assign dst_w     = w_in;

endmodule

// File: tb/tb_disto_loader.sv
// Self-checking bench for disto_loader: vector table of blocks plus reset corner sequences.
module tb_disto_loader;

  localparam int TMO = 20;

  logic           clk;
  logic           rst;
  logic           row_valid;
  logic           row_ready;
  logic [127:0]   row_a;
  logic [127:0]   row_b;
  logic [3:0]     row_tag;
  logic [4095:0]  w_in;
  logic           dst_start;
  logic [2047:0]  dst_ina;
  logic [2047:0]  dst_inb;
  logic [4095:0]  dst_w;
  logic [31:0]    dst_sum;
  logic           dst_done;
  logic           res_valid;
  logic           res_ready;
  logic [31:0]    res_sum;
  logic [3:0]     res_tag;
  logic           res_err;

  int checks   = 0;
  int failures = 0;

  disto_loader #(.BIT_WIDTH(8), .BLOCK_SIZE(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_a(row_a), .row_b(row_b), .row_tag(row_tag), .w_in(w_in),
    .dst_start(dst_start), .dst_ina(dst_ina), .dst_inb(dst_inb), .dst_w(dst_w),
    .dst_sum(dst_sum), .dst_done(dst_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_tag(res_tag), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pat: 0 = fixed pattern (r*16+c / 0xFF), 1 = random. gaps: 0 none, 1 alternate, 2 random.
  // lat: cycles from start to done; 0 = no done at all.
  typedef struct {
    int          pat;
    logic [3:0]  tag;
    int          lat;
    int          rdy_wait;
    int          gaps;
    bit          stray;
    logic [31:0] sum;
    logic [31:0] exp_sum;
    logic [3:0]  exp_tag;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int pat, logic [3:0] tag, int lat, int rdy, int gaps, bit stray,
                              logic [31:0] sum, logic [31:0] es, logic [3:0] et, logic ee);
    vec_t v;
    v.pat = pat; v.tag = tag; v.lat = lat; v.rdy_wait = rdy; v.gaps = gaps; v.stray = stray;
    v.sum = sum; v.exp_sum = es; v.exp_tag = et; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_row_ready"}, row_ready, 1);
    chk({tagname, "_dst_start"}, dst_start, 0);
    chk({tagname, "_res_valid"}, res_valid, 0);
    chk({tagname, "_res_sum"},   res_sum, 0);
    chk({tagname, "_res_tag"},   res_tag, 0);
    chk({tagname, "_res_err"},   res_err, 0);
    chk({tagname, "_ina_zero"},  (dst_ina == '0), 1);
    chk({tagname, "_inb_zero"},  (dst_inb == '0), 1);
  endtask

  task automatic beat(input logic [127:0] a, input logic [127:0] b, input logic [3:0] tag);
    row_valid = 1'b1; row_a = a; row_b = b; row_tag = tag;
    step();
  endtask

  task automatic run_block(input vec_t v, input string nm);
    logic [7:0] ea [256];
    logic [7:0] eb [256];
    logic [127:0] ra, rb;
    int ngap, nmis_a, nmis_b, wait_n;

    for (int i = 0; i < 128; i++) w_in[32*i +: 32] = $urandom;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        ea[r*16+c] = (v.pat == 0) ? 8'(r*16 + c) : 8'($urandom);
        eb[r*16+c] = (v.pat == 0) ? 8'hFF : 8'($urandom);
        ra[8*c +: 8] = ea[r*16+c];
        rb[8*c +: 8] = eb[r*16+c];
      end
      ngap = (v.gaps == 1) ? 1 : (v.gaps == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ngap; g++) begin
        row_valid = 1'b0; row_a = rnd128(); row_b = rnd128(); row_tag = ~v.tag;
        dst_done = v.stray && (g == 0); dst_sum = 32'hDEAD;
        chk({nm, "_gap_row_ready"}, row_ready, 1);
        chk({nm, "_gap_dst_start"}, dst_start, 0);
        step();
      end
      row_valid = 1'b1; row_a = ra; row_b = rb;
      row_tag = (r == 0) ? v.tag : ~v.tag;
      dst_done = v.stray && (r == 4); dst_sum = 32'hDEAD;
      chk({nm, "_beat_row_ready"}, row_ready, 1);
      chk({nm, "_beat_dst_start"}, dst_start, 0);
      chk({nm, "_beat_res_valid"}, res_valid, 0);
      step();
    end

    // FIRE cycle: junk row held valid must not be consumed; a same-cycle done must be ignored
    row_valid = 1'b1; row_a = rnd128(); row_b = rnd128(); row_tag = ~v.tag;
    dst_done = v.stray; dst_sum = 32'hDEAD;
    chk({nm, "_fire_start"}, dst_start, 1);
    chk({nm, "_fire_row_ready"}, row_ready, 0);
    chk({nm, "_dst_w"}, (dst_w === w_in), 1);
    nmis_a = 0; nmis_b = 0;
    for (int i = 0; i < 256; i++) begin
      if (dst_ina[8*i +: 8] !== ea[i]) nmis_a++;
      if (dst_inb[8*i +: 8] !== eb[i]) nmis_b++;
    end
    chk({nm, "_ina_bytes_bad"}, nmis_a, 0);
    chk({nm, "_inb_bytes_bad"}, nmis_b, 0);
    if (v.pat == 0) chk({nm, "_ina_byte37"}, dst_ina[37*8 +: 8], 32'h25);

    wait_n = (v.lat > 0) ? v.lat : TMO;
    for (int i = 1; i <= wait_n; i++) begin
      step();
      chk({nm, "_wait_start"}, dst_start, 0);
      chk({nm, "_wait_res_valid"}, res_valid, 0);
      chk({nm, "_wait_row_ready"}, row_ready, 0);
      dst_done = (v.lat > 0) && (i == v.lat);
      dst_sum  = dst_done ? v.sum : 32'hDEAD;
    end
    step();
    for (int k = 0; k <= v.rdy_wait; k++) begin
      chk({nm, "_out_valid"}, res_valid, 1);
      chk({nm, "_out_sum"}, res_sum, v.exp_sum);
      chk({nm, "_out_tag"}, res_tag, v.exp_tag);
      chk({nm, "_out_err"}, res_err, v.exp_err);
      chk({nm, "_out_row_ready"}, row_ready, 0);
      dst_done  = v.stray && (k == 0);
      dst_sum   = 32'hDEAD;
      res_ready = (k == v.rdy_wait);
      step();
    end
    res_ready = 1'b0; row_valid = 1'b0; dst_done = 1'b0;
    chk({nm, "_post_row_ready"}, row_ready, 1);
    chk({nm, "_post_res_valid"}, res_valid, 0);
    nmis_a = 0;
    for (int i = 0; i < 256; i++) if (dst_ina[8*i +: 8] !== ea[i]) nmis_a++;
    chk({nm, "_ina_held_bad"}, nmis_a, 0);
  endtask

  initial begin
    rst = 1'b1; row_valid = 1'b0; row_a = '0; row_b = '0; row_tag = '0;
    w_in = '0; dst_sum = '0; dst_done = 1'b0; res_ready = 1'b0;

    vecs.push_back(mk(0, 4'h5, 8, 0, 0, 0, 32'h1234, 32'h1234, 4'h5, 0));
    vecs.push_back(mk(1, 4'hA, 3, 10, 1, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'hA, 0));
    vecs.push_back(mk(1, 4'h3, 5, 2, 2, 1, 32'h0000_0BEE, 32'h0000_0BEE, 4'h3, 0));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 4'hF, 0));
    vecs.push_back(mk(1, 4'h0, TMO, 1, 2, 1, 32'h8000_0001, 32'h8000_0001, 4'h0, 0));
`ifdef DISTO_LOADER_TIMEOUT_EN
    vecs.push_back(mk(1, 4'h7, 0, 3, 0, 1, 32'h0, 32'hFFFF_FFFF, 4'h7, 1));
    vecs.push_back(mk(1, 4'h8, 4, 0, 0, 0, 32'h0000_5555, 32'h0000_5555, 4'h8, 0));
`else
    vecs.push_back(mk(1, 4'h7, 45, 3, 0, 1, 32'h0000_0777, 32'h0000_0777, 4'h7, 0));
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("rst0");

    foreach (vecs[i]) run_block(vecs[i], $sformatf("v%0d", i));

    // reset after row 7 discards the partial block
    for (int r = 0; r < 8; r++) beat(rnd128(), rnd128(), 4'h9);
    row_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_row7");
    run_block(mk(1, 4'h6, 6, 1, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'h6, 0), "after_rst7");

    // reset after FIRE; the in-flight done that follows must be ignored
    for (int r = 0; r < 16; r++) beat(rnd128(), rnd128(), 4'hC);
    row_valid = 1'b0;
    chk("rstfire_start", dst_start, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_fire");
    dst_done = 1'b1; dst_sum = 32'hDEAD;
    step();
    dst_done = 1'b0;
    chk("rstfire_stray_valid", res_valid, 0);
    chk("rstfire_stray_ready", row_ready, 1);
    run_block(mk(0, 4'h2, 2, 0, 0, 0, 32'h0000_4321, 32'h0000_4321, 4'h2, 0), "after_rstfire");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
